// File: rtl/ram_io_responder.sv
// ram_io_responder: RAM-side responder for the byte-serial memory bus.
// Serves one byte per cycle from an on-chip byte RAM (1-cycle registered read)
// and decodes an I/O window holding a UART TX FIFO, a UART RX byte and a
// simulation-end register.
// Optional feature macro: RAM_IO_STATUS_EN enables the status byte at I/O
// offset 4 and the sticky tx_overflow flag.
module ram_io_responder #(
  parameter int ADDR_WIDTH = 17,
  parameter int IO_BIT     = 17,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        rw_req_in,
  input  logic [31:0] mem_addr_in,
  input  logic [7:0]  mem_val_in,
  output logic [7:0]  mem_val_read_out,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ack,
  output logic        io_full,
  output logic        tx_overflow,
  output logic        sim_end
);

  localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};

  // Storage
  logic [7:0] ram_r      [0:(1<<ADDR_WIDTH)-1];
  logic [7:0] fifo_mem_r [0:FIFO_DEPTH-1];

  // FIFO and edge-detect state
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;
  logic [31:0]      prev_addr_r;

  // Decode
  logic                  io_s;
  logic [ADDR_WIDTH-1:0] idx_s;
  logic [2:0]            off_s;
  logic                  ram_we_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  push_acc_s;
  logic                  drop_s;
  logic                  sim_end_set_s;
  logic                  prev_rx_s;
  logic                  ack_s;
  logic [7:0]            status_s;
  logic [7:0]            rd_next_s;
  logic                  unused_s;

  assign io_s  = mem_addr_in[IO_BIT];
  assign idx_s = mem_addr_in[ADDR_WIDTH-1:0];
  assign off_s = mem_addr_in[2:0];

  // Upper address bits are intentionally ignored (RAM aliases).
  assign unused_s = ^mem_addr_in;

  assign uart_tx_valid = (count_r != CNT_ZERO);
  assign uart_tx_data  = uart_tx_valid ? fifo_mem_r[head_r] : 8'h00;
  assign io_full       = (count_r == CNT_FULL);

  assign ram_we_s      = rdy_in && !io_s && rw_req_in;
  assign push_s        = rdy_in && io_s && rw_req_in && (off_s == 3'd0);
  assign sim_end_set_s = rdy_in && io_s && rw_req_in && (off_s == 3'd4);
  assign pop_s         = rdy_in && uart_tx_valid && uart_tx_ready;
  // A pop in the same cycle frees the slot the push needs.
  assign push_acc_s    = push_s && (!io_full || pop_s);
  assign drop_s        = push_s && !push_acc_s;

  // The RX window is "any address with the I/O bit set and offset 0".
  assign prev_rx_s = prev_addr_r[IO_BIT] && (prev_addr_r[2:0] == 3'd0);
  assign ack_s     = rdy_in && !rw_req_in && io_s && (off_s == 3'd0)
                     && uart_rx_valid && !prev_rx_s;

`ifdef RAM_IO_STATUS_EN
  assign status_s = {5'b00000, tx_overflow, uart_rx_valid, ~io_full};
`else
  assign status_s = 8'h00;
`endif

  // Select the byte that the read-data register captures this cycle
  always_comb begin
    rd_next_s = 8'h00;
    if (io_s) begin
      if (!rw_req_in) begin
        case (off_s)
          3'd0:    rd_next_s = uart_rx_valid ? uart_rx_data : 8'h00;
          3'd4:    rd_next_s = status_s;
          default: rd_next_s = 8'h00;
        endcase
      end else begin
        rd_next_s = 8'h00;
      end
    end else begin
      if (!rw_req_in) begin
        rd_next_s = ram_r[idx_s];
      end else begin
        rd_next_s = 8'h00;
      end
    end
  end

  // RAM write port; contents survive reset
  always_ff @(posedge clk_in) begin
    if (rst_in && ram_we_s) begin
      ram_r[idx_s] <= mem_val_in;
    end
  end

  // TX FIFO storage write at the tail
  always_ff @(posedge clk_in) begin
    if (rst_in && push_acc_s) begin
      fifo_mem_r[tail_r] <= mem_val_in;
    end
  end

  // Control registers: read data, FIFO pointers/count, RX ack, sim_end
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      mem_val_read_out <= 8'h00;
      head_r           <= PTR_ZERO;
      tail_r           <= PTR_ZERO;
      count_r          <= CNT_ZERO;
      uart_rx_ack      <= 1'b0;
      sim_end          <= 1'b0;
      prev_addr_r      <= 32'h0000_0000;
    end else if (rdy_in) begin
      mem_val_read_out <= rd_next_s;
      uart_rx_ack      <= ack_s;
      prev_addr_r      <= mem_addr_in;
      if (sim_end_set_s) begin
        sim_end <= 1'b1;
      end
      if (pop_s) begin
        head_r <= head_r + PTR_ONE;
      end
      if (push_acc_s) begin
        tail_r <= tail_r + PTR_ONE;
      end
      case ({push_acc_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

`ifdef RAM_IO_STATUS_EN
  // Sticky record that a push was dropped on a full FIFO
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      tx_overflow <= 1'b0;
    end else if (rdy_in && drop_s) begin
      tx_overflow <= 1'b1;
    end
  end
`else
  logic unused_drop_s;
  assign unused_drop_s = drop_s;
  assign tx_overflow   = 1'b0;
`endif

endmodule
